// File: rtl/mem_req_arbiter.sv
// ----------------------------------------------------------------------------
// mem_req_arbiter
//
// This module shares the single memory-controller port between two requesters:
// the I$ miss path, which only reads, and the D$ miss/writeback path. One owner
// holds the port at a time, and it keeps the grant until its access completes
// or it drops the request.
//
// D$ requests win arbitration by default. A streak counter caps the number of
// consecutive D$ grants that can go through while an I$ request is waiting, so
// instruction refills always make progress.
//
// Ports
//   CLK            clock
//   nRST           asynchronous active-low reset
//   icache_REN     I$ read request, held until icache_wait=0
//   icache_addr    I$ byte address
//   icache_wait    0 only in the cycle the I$ access completes
//   icache_load    read data for I$ (mirrors mem_load)
//   dcache_REN     D$ read request, held until dcache_wait=0
//   dcache_WEN     D$ write request, held until dcache_wait=0
//   dcache_addr    D$ byte address
//   dcache_store   D$ write data
//   dcache_wait    0 only in the cycle the D$ access completes
//   dcache_load    read data for D$ (mirrors mem_load)
//   mem_REN        read strobe to memory controller
//   mem_WEN        write strobe to memory controller
//   mem_addr       address to memory controller
//   mem_store      write data to memory controller
//   mem_load       read data from memory controller
//   mem_ready      in-flight access completes this cycle
//   arb_state_out  current arbiter state (debug)
//   arb_error      sticky protocol error flag
// ----------------------------------------------------------------------------
module mem_req_arbiter #(
    parameter int MAX_D_STREAK = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        icache_REN,
    input  logic [31:0] icache_addr,
    output logic        icache_wait,
    output logic [31:0] icache_load,
    input  logic        dcache_REN,
    input  logic        dcache_WEN,
    input  logic [31:0] dcache_addr,
    input  logic [31:0] dcache_store,
    output logic        dcache_wait,
    output logic [31:0] dcache_load,
    output logic        mem_REN,
    output logic        mem_WEN,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_store,
    input  logic [31:0] mem_load,
    input  logic        mem_ready,
    output logic [1:0]  arb_state_out,
    output logic        arb_error
);

    typedef enum logic [1:0] {
        ARB_IDLE = 2'b00,
        ARB_I    = 2'b01,
        ARB_D    = 2'b10,
        ARB_BAD  = 2'b11
    } arb_state_t;

    localparam int            SW         = $clog2(MAX_D_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

    function automatic logic [SW-1:0] streak_sat_inc(input logic [SW-1:0] s);
        if (s >= STREAK_MAX) begin
            return STREAK_MAX;
        end
        return s + SW'(1);
    endfunction

    arb_state_t    state_q, state_d;
    logic [SW-1:0] streak_q, streak_d;
    logic          err_q, err_d;
    logic          dwen_prev_q;
    logic          d_req;

    assign d_req = dcache_REN | dcache_WEN;

    // Registered control state
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= ARB_IDLE;
            streak_q    <= '0;
            err_q       <= 1'b0;
            dwen_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            streak_q    <= streak_d;
            err_q       <= err_d;
            dwen_prev_q <= dcache_WEN;
        end
    end

    // Next-state and mem-side outputs; strobes follow the owner's live request
    always_comb begin
        state_d     = state_q;
        streak_d    = streak_q;
        err_d       = err_q;
        mem_REN     = 1'b0;
        mem_WEN     = 1'b0;
        mem_addr    = '0;
        mem_store   = '0;
        icache_wait = 1'b1;
        dcache_wait = 1'b1;

        // A simultaneous read and write from D$ is illegal in any state.
        if (dcache_REN && dcache_WEN) begin
            err_d = 1'b1;
        end

        case (state_q)
            ARB_IDLE: begin
                if (d_req && (!icache_REN || (streak_q < STREAK_MAX))) begin
                    state_d = ARB_D;
                end else if (icache_REN) begin
                    state_d = ARB_I;
                end
            end

            ARB_I: begin
                mem_REN     = icache_REN;
                mem_addr    = icache_addr;
                icache_wait = ~mem_ready;
                if (!icache_REN) begin
                    // Fetch restart: abandon the access, streak untouched.
                    state_d = ARB_IDLE;
                end else if (mem_ready) begin
                    state_d  = ARB_IDLE;
                    streak_d = '0;
                end
            end

            ARB_D: begin
                mem_REN     = dcache_REN;
                mem_WEN     = dcache_WEN;
                mem_addr    = dcache_addr;
                mem_store   = dcache_store;
                dcache_wait = ~mem_ready;
                if (!d_req) begin
                    // Withdrawing a write mid-flight may leave memory half-updated.
                    state_d = ARB_IDLE;
                    if (dwen_prev_q) begin
                        err_d = 1'b1;
                    end
                end else if (mem_ready) begin
                    state_d  = ARB_IDLE;
                    streak_d = icache_REN ? streak_sat_inc(streak_q) : '0;
                end
            end

            default: begin
                state_d = ARB_IDLE;
                err_d   = 1'b1;
            end
        endcase
    end

    assign icache_load   = mem_load;
    assign dcache_load   = mem_load;
    assign arb_state_out = state_q;
    assign arb_error     = err_q;

endmodule
